dyser_output_port: RTL



---
 rtl/dyser_output_port_if.sv | 38 +++
 rtl/dyser_output_port.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dyser_output_port_if.sv
// -----------------------------------------------------------------------------
// dyser_output_port_if
//
// Host-side handshake bundle of the DySER output port. The port presents the
// head-of-FIFO token (out_data/out_valid) and the host answers with out_ready.
//
// Signals:
//   out_data   head-of-FIFO data, `PATH_WIDTH-1 bits
//   out_valid  FIFO non-empty
//   out_ready  host accepts the head token this cycle
//
// Modports:
//   master  the output port (drives out_data/out_valid, samples out_ready)
//   slave   the host        (samples out_data/out_valid, drives out_ready)
// -----------------------------------------------------------------------------
`ifndef PATH_WIDTH
`define PATH_WIDTH 33
`endif

interface dyser_output_port_if #(
    parameter int DATA_W = `PATH_WIDTH - 1
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/dyser_output_port.sv
// -----------------------------------------------------------------------------
// dyser_output_port
//
// Sink that terminates one DySER edge-switch output direction. Tokens whose
// valid bit is set are captured into a small FIFO and offered to the host with
// a valid/ready handshake. Every token the host consumes frees one FIFO entry
// and is returned to the upstream switch stage as a one-cycle credit pulse,
// closing the credit loop the switch's c_in_* inputs expect.
//
// Parameters:
//   ADDR_W        FIFO address width, DEPTH = 2**ADDR_W (1..5)
//   INIT_CREDITS  credits held upstream after reset; equals DEPTH and is
//                 used only to detect a token arriving with no credit behind it
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   d_in       switch output bus: [0] ready (ignored), [1] valid,
//              [`PATH_WIDTH:2] data
//   c_out      credit return, one-cycle pulse per freed entry
//   host       host handshake (out_data, out_valid, out_ready), master side
//   count      FIFO occupancy, 0..DEPTH
//   overflow   sticky: a token arrived while full and nothing was popped
//   tok_count  tokens delivered to the host
//
// Build option:
//   DYSER_OPORT_STATS_EN  when defined, tok_count is a free-running 32-bit
//                         delivered-token counter; otherwise it is tied to 0
//                         and no counter is built.
//
// Timing: every output is a flop, so nothing depends combinationally on d_in
// or out_ready. A token pushed at edge N is visible on out_data with
// out_valid=1 right after edge N; there is no same-edge bypass to the host.
// -----------------------------------------------------------------------------
`ifndef PATH_WIDTH
`define PATH_WIDTH 33
`endif

module dyser_output_port #(
    parameter int ADDR_W       = 2,
    parameter int INIT_CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [`PATH_WIDTH:0]  d_in,
    output logic                  c_out,
    dyser_output_port_if.master   host,
    output logic [ADDR_W:0]       count,
    output logic                  overflow,
    output logic [31:0]           tok_count
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DATA_W = `PATH_WIDTH - 1;

    localparam logic [ADDR_W:0]   DEPTH_CNT  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CREDIT_CNT = INIT_CREDITS[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Input bus decode. The upstream ready bit carries no meaning here because
    // flow control is entirely credit based.
    // -------------------------------------------------------------------------
    logic              tok_valid;
    logic [DATA_W-1:0] tok_data;
    logic              unused_upstream_ready;

    assign tok_valid             = d_in[1];
    assign tok_data              = d_in[`PATH_WIDTH:2];
    assign unused_upstream_ready = d_in[0];

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wptr_reg, wptr_next;
    logic [ADDR_W-1:0] rptr_reg, rptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] head_reg, head_next;
    logic              c_out_reg;
    logic              overflow_reg, overflow_next;

    // -------------------------------------------------------------------------
    // Push / pop qualification.
    // Fullness comes from the occupancy counter, never from pointer equality,
    // so wptr==rptr is unambiguous. A full FIFO still accepts a token when the
    // head leaves in the same cycle, because the freed slot is the one the
    // write pointer is sitting on.
    // -------------------------------------------------------------------------
    logic full;
    logic pop;
    logic push;
    logic ovf_hit;

    assign full    = (count_reg == DEPTH_CNT);
    assign pop     = valid_reg & host.out_ready;
    assign push    = tok_valid & (~full | pop);
    // A token with no free entry and no departing head means the upstream
    // stage sent without a credit; the token is lost and the error latches.
    assign ovf_hit = tok_valid & (count_reg == CREDIT_CNT) & ~pop;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        count_next    = count_reg;
        head_next     = head_reg;
        overflow_next = overflow_reg | ovf_hit;

        if (push) begin
            wptr_next = wptr_reg + PTR_ONE;
        end
        if (pop) begin
            rptr_next = rptr_reg + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase

        valid_next = (count_next != '0);

        // The head register is the registered read port of the FIFO storage.
        // It must show mem[rptr_next] after the edge; when that slot is the
        // one being written at this very edge (FIFO empty before, or a single
        // entry being replaced by a push+pop), the incoming token is taken
        // directly since the array write has not landed yet. When the FIFO
        // becomes empty the head simply holds its last value.
        if (count_next != '0) begin
            if (push && (wptr_reg == rptr_next)) begin
                head_next = tok_data;
            end else begin
                head_next = mem[rptr_next];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage: write-only array, read through head_reg.
    // Contents are not reset; occupancy and pointers define what is live.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= tok_data;
        end
    end

    // -------------------------------------------------------------------------
    // Control registers. Reset also cancels a credit pulse that would have
    // followed a pop in the cycle the reset arrived.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            valid_reg    <= 1'b0;
            head_reg     <= '0;
            c_out_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            valid_reg    <= valid_next;
            head_reg     <= head_next;
            c_out_reg    <= pop;
            overflow_reg <= overflow_next;
        end
    end

    // -------------------------------------------------------------------------
    // Delivered-token statistics
    // -------------------------------------------------------------------------
`ifdef DYSER_OPORT_STATS_EN
    logic [31:0] tok_count_reg;

    // Free-running: wraps from all-ones back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tok_count_reg <= '0;
        end else if (pop) begin
            tok_count_reg <= tok_count_reg + 32'd1;
        end
    end

    assign tok_count = tok_count_reg;
`else
    assign tok_count = '0;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign host.out_data  = head_reg;
    assign host.out_valid = valid_reg;
    assign c_out          = c_out_reg;
    assign count          = count_reg;
    assign overflow       = overflow_reg;

endmodule
